// File: rtl/card_pick_ctrl.sv
// card_pick_ctrl: turns debounced button presses into a one-hot card cursor and
// single-cycle deal strobes for the two handout stages. Turns alternate between
// the players, and the cursor skips any card that either player already holds.
//
// Ports:
//   clk, reset                   clock; asynchronous active-high reset
//   start                        level; a rising edge begins dealing
//   btn_left/right/confirm       levels; rising edges move the cursor down/up or deal
//   p1_card, p2_card             taken-card masks read back from the handout stages
//   cardselect                   registered one-hot of the cursor, or 0
//   handout_p1/p2_pulse          registered one-cycle deal strobes
//   cursor                       current card index, 0..NCARD-1
//   turn                         0 = player 1, 1 = player 2
//   done                         high once every card is taken
module card_pick_ctrl #(
    parameter int unsigned NCARD = 9,
    parameter int unsigned CW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_confirm,
    input  logic [NCARD-1:0] p1_card,
    input  logic [NCARD-1:0] p2_card,
    output logic [NCARD-1:0] cardselect,
    output logic             handout_p1_pulse,
    output logic             handout_p2_pulse,
    output logic [CW-1:0]    cursor,
    output logic             turn,
    output logic             done
);

    typedef enum logic [2:0] {
        StIdle, StSeek, StSelect, StIssue, StHold, StSettle, StDone
    } state_e;

    localparam logic [CW-1:0] LastIdx = CW'(NCARD - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cursor_q, cursor_d;
    logic             turn_q, turn_d;
    logic             dir_q, dir_d;  // 1 = up
    logic [NCARD-1:0] cs_q, cs_d;
    logic             p1p_q, p1p_d;
    logic             p2p_q, p2p_d;
    logic             done_q, done_d;
    // Input history {start, left, right, confirm}
    logic [3:0]       prev_q, prev_d;

    logic [NCARD-1:0] used;
    logic             all_taken;
    logic             start_evt, left_evt, right_evt, confirm_evt;

    function automatic logic [CW-1:0] cur_inc(input logic [CW-1:0] c);
        return (c == LastIdx) ? '0 : c + 1'b1;
    endfunction

    function automatic logic [CW-1:0] cur_dec(input logic [CW-1:0] c);
        return (c == '0) ? LastIdx : c - 1'b1;
    endfunction

    function automatic logic [NCARD-1:0] one_hot(input logic [CW-1:0] c);
        return {{(NCARD-1){1'b0}}, 1'b1} << c;
    endfunction

    assign used      = p1_card | p2_card;
    assign all_taken = &used;

    assign start_evt   = start       & ~prev_q[3];
    assign left_evt    = btn_left    & ~prev_q[2];
    assign right_evt   = btn_right   & ~prev_q[1];
    assign confirm_evt = btn_confirm & ~prev_q[0];

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        turn_d   = turn_q;
        dir_d    = dir_q;
        cs_d     = cs_q;
        p1p_d    = 1'b0;
        p2p_d    = 1'b0;
        done_d   = done_q;
        prev_d   = {start, btn_left, btn_right, btn_confirm};

        // Events not consumed by the current state are simply dropped.
        unique case (state_q)
            StIdle: begin
                cs_d = '0;
                if (start_evt) begin
                    state_d = StSeek;
                    dir_d   = 1'b1;
                end
            end
            StSeek: begin
                cs_d = '0;
                if (all_taken) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else if (used[cursor_q]) begin
                    cursor_d = dir_q ? cur_inc(cursor_q) : cur_dec(cursor_q);
                end else begin
                    state_d = StSelect;
                    // Loaded on entry so cardselect is valid in the first SELECT cycle.
                    cs_d    = one_hot(cursor_q);
                end
            end
            StSelect: begin
                if (confirm_evt) begin
                    state_d = StIssue;
                end else if (right_evt) begin
                    cursor_d = cur_inc(cursor_q);
                    dir_d    = 1'b1;
                    cs_d     = '0;
                    state_d  = StSeek;
                end else if (left_evt) begin
                    cursor_d = cur_dec(cursor_q);
                    dir_d    = 1'b0;
                    cs_d     = '0;
                    state_d  = StSeek;
                end
            end
            StIssue: begin
                // The mask may have changed since the confirm; never deal a taken card.
                if (used[cursor_q]) begin
                    state_d = StSeek;
                    dir_d   = 1'b1;
                    cs_d    = '0;
                end else begin
                    p1p_d   = ~turn_q;
                    p2p_d   = turn_q;
                    state_d = StHold;
                end
            end
            StHold: begin
                state_d = StSettle;
            end
            StSettle: begin
                cs_d    = '0;
                turn_d  = ~turn_q;
                dir_d   = 1'b1;
                state_d = StSeek;
            end
            StDone: begin
                cs_d   = '0;
                done_d = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cursor_q <= '0;
            turn_q   <= 1'b0;
            dir_q    <= 1'b1;
            cs_q     <= '0;
            p1p_q    <= 1'b0;
            p2p_q    <= 1'b0;
            done_q   <= 1'b0;
            // All ones so levels held through reset do not register as edges.
            prev_q   <= '1;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            turn_q   <= turn_d;
            dir_q    <= dir_d;
            cs_q     <= cs_d;
            p1p_q    <= p1p_d;
            p2p_q    <= p2p_d;
            done_q   <= done_d;
            prev_q   <= prev_d;
        end
    end

    assign cardselect       = cs_q;
    assign handout_p1_pulse = p1p_q;
    assign handout_p2_pulse = p2p_q;
    assign cursor           = cursor_q;
    assign turn             = turn_q;
    assign done             = done_q;

endmodule
